// File: rtl/board_renderer.sv
// board_renderer: three-stage game-board pixel generator (owner colour, grid lines, cursor box).
// Define BOARD_RENDERER_BLINK_EN to make the cursor box blink every BLINK_FRAMES frames.
module board_renderer #(
  parameter int WIDTH        = 12,
  parameter int BOARD_X0     = 240,
  parameter int BOARD_Y0     = 140,
  parameter int CELL_LOG2    = 5,
  parameter int COLS         = 10,
  parameter int ROWS         = 10,
  parameter int BLINK_FRAMES = 30,
  localparam int AW          = $clog2(ROWS * COLS)
) (
  input  logic             clk_vga,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] hdata,
  input  logic [WIDTH-1:0] vdata,
  input  logic [3:0]       cursor_x,
  input  logic [3:0]       cursor_y,
  output logic [AW-1:0]    cell_addr_o,
  input  logic [7:0]       cell_data_i,
  output logic [7:0]       gen_red,
  output logic [7:0]       gen_green,
  output logic [7:0]       gen_blue,
  output logic             use_gen
);

  localparam int CELL = 1 << CELL_LOG2;
  localparam int CW   = WIDTH - CELL_LOG2;
  localparam logic [WIDTH-1:0] X0 = WIDTH'(BOARD_X0);
  localparam logic [WIDTH-1:0] X1 = WIDTH'(BOARD_X0 + (COLS << CELL_LOG2));
  localparam logic [WIDTH-1:0] Y0 = WIDTH'(BOARD_Y0);
  localparam logic [WIDTH-1:0] Y1 = WIDTH'(BOARD_Y0 + (ROWS << CELL_LOG2));

  logic [WIDTH-1:0]     dx, dy;
  logic [CW-1:0]        col, row;
  logic                 in_board_d, in_board1_q, in_board2_q;
  logic [CELL_LOG2-1:0] lx_d, lx1_q, lx2_q;
  logic [CELL_LOG2-1:0] ly_d, ly1_q, ly2_q;
  logic                 hit_d, hit1_q, hit2_q;
  logic [AW-1:0]        cell_addr_d, cell_addr_q;
  logic                 blink_on;
  logic [7:0]           red_d, red_q, green_d, green_q, blue_d, blue_q;
  logic                 use_gen_d, use_gen_q;
  logic                 unused_data;

  assign unused_data = ^cell_data_i[5:0];

  function automatic logic near_edge(input logic [CELL_LOG2-1:0] p);
    return (p < CELL_LOG2'(2)) || (p >= CELL_LOG2'(CELL - 2));
  endfunction

  // Offsets are only formed once the coordinate is known to be right of/below the origin.
  always_comb begin
    in_board_d  = (hdata >= X0) && (hdata < X1) && (vdata >= Y0) && (vdata < Y1);
    dx          = (hdata >= X0) ? hdata - X0 : '0;
    dy          = (vdata >= Y0) ? vdata - Y0 : '0;
    col         = dx[WIDTH-1:CELL_LOG2];
    row         = dy[WIDTH-1:CELL_LOG2];
    lx_d        = dx[CELL_LOG2-1:0];
    ly_d        = dy[CELL_LOG2-1:0];
    cell_addr_d = in_board_d ? AW'(int'(row) * COLS + int'(col)) : '0;
    hit_d       = in_board_d && blink_on &&
                  (int'(cursor_x) < COLS) && (int'(cursor_y) < ROWS) &&
                  (int'(col) == int'(cursor_x)) && (int'(row) == int'(cursor_y));
  end

`ifdef BOARD_RENDERER_BLINK_EN
  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FCW-1:0] frame_cnt_d, frame_cnt_q;
  logic           blink_on_d, blink_on_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if ((hdata == '0) && (vdata == '0)) begin
      if (frame_cnt_q == FCW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign blink_on = blink_on_q;
`else
  assign blink_on = 1'b1;
`endif

  // Owner data is only consulted on board, so off-board pixels ignore undefined RAM data.
  always_comb begin
    red_d     = '0;
    green_d   = '0;
    blue_d    = '0;
    use_gen_d = 1'b0;
    if (in_board2_q) begin
      if (hit2_q && (near_edge(lx2_q) || near_edge(ly2_q))) begin
        {use_gen_d, red_d, green_d, blue_d} = {1'b1, 24'hFFFFFF};
      end else if ((lx2_q == '0) || (ly2_q == '0)) begin
        {use_gen_d, red_d, green_d, blue_d} = {1'b1, 24'h404040};
      end else begin
        case (cell_data_i[7:6])
          2'd1:    {use_gen_d, red_d, green_d, blue_d} = {1'b1, 24'hFF2020};
          2'd2:    {use_gen_d, red_d, green_d, blue_d} = {1'b1, 24'h2040FF};
          2'd3:    {use_gen_d, red_d, green_d, blue_d} = {1'b1, 24'h808080};
          default: {use_gen_d, red_d, green_d, blue_d} = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      in_board1_q <= 1'b0;
      lx1_q       <= '0;
      ly1_q       <= '0;
      hit1_q      <= 1'b0;
      cell_addr_q <= '0;
      in_board2_q <= 1'b0;
      lx2_q       <= '0;
      ly2_q       <= '0;
      hit2_q      <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      use_gen_q   <= 1'b0;
    end else begin
      in_board1_q <= in_board_d;
      lx1_q       <= lx_d;
      ly1_q       <= ly_d;
      hit1_q      <= hit_d;
      cell_addr_q <= cell_addr_d;
      in_board2_q <= in_board1_q;
      lx2_q       <= lx1_q;
      ly2_q       <= ly1_q;
      hit2_q      <= hit1_q;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      use_gen_q   <= use_gen_d;
    end
  end

  assign cell_addr_o = cell_addr_q;
  assign gen_red     = red_q;
  assign gen_green   = green_q;
  assign gen_blue    = blue_q;
  assign use_gen     = use_gen_q;

endmodule

// File: doc/board_renderer.md
# board_renderer

Game-layer pixel generator that sits directly upstream of the pixel controller's layer mux. It takes the raster coordinate from the VGA timing generator and fetches the corresponding board cell from the synchronous cell RAM. It then produces `gen_red/green/blue` and `use_gen` for that pixel: cell owner colour, grid lines, and a blinking cursor box. Output is a fixed 3-cycle pipeline; the integrator delays sync/DE by 3 cycles to match.

## Interface
- `WIDTH`, 12: coordinate width.
- `BOARD_X0`, 240: left pixel of board.
- `BOARD_Y0`, 140: top pixel of board.
- `CELL_LOG2`, 5: log2 of cell edge in pixels (32).
- `COLS`, 10: board columns.
- `ROWS`, 10: board rows.
- `BLINK_FRAMES`, 30: frames per cursor blink phase.

Ports:
- `clk_vga` in 1: pixel clock.
- `reset_n` in 1: asynchronous active-low reset.
- `hdata` in WIDTH: current raster x.
- `vdata` in WIDTH: current raster y.
- `cursor_x` in 4: cursor column.
- `cursor_y` in 4: cursor row.
- `cell_addr_o` out AW=$clog2(ROWS*COLS): cell RAM read address, registered.
- `cell_data_i` in 8: RAM read data, valid one cycle after address. Bits [7:6] owner; bits [5:0] unused here.
- `gen_red`, `gen_green`, `gen_blue` out 8 each: generated colour.
- `use_gen` out 1: 1 means the generated colour overrides the background.

## Operation
- Stage 1, edge E1: register `in_board = (h >= X0) && (h < X0+COLS<<CELL_LOG2) && (v >= Y0) && (v < Y0+ROWS<<CELL_LOG2)`.
  - `col = (h-X0)>>CELL_LOG2`, `row = (v-Y0)>>CELL_LOG2`.
  - `lx`/`ly` are the low CELL_LOG2 bits of `h-X0` and `v-Y0`.
  - `cell_addr_o = row*COLS+col` when `in_board`, else 0.
  - Subtractions are WIDTH-bit; compare before subtracting so there is no wrap.
- Stage 2, edge E2: RAM registers data. The block forwards `in_board`, `lx`, `ly`, and the cursor-hit flag.
  - Cursor hit: `col==cursor_x && row==cursor_y`, with `cursor_x<COLS` and `cursor_y<ROWS`.
- Stage 3, edge E3: register outputs, using `cell_data_i` and the stage-2 flags. Priority order:
  1. `!in_board`: `use_gen=0`, rgb=0.
  2. Cursor hit, blink phase on, and `lx` or `ly` ∈ {0, 1, CELL-2, CELL-1}: white FFFFFF, `use_gen=1`.
  3. `lx==0` or `ly==0`: grid grey 404040, `use_gen=1`.
  4. Owner 1: FF2020. Owner 2: 2040FF. Owner 3: 808080. All with `use_gen=1`.
  5. Owner 0: `use_gen=0`, rgb=0.
- Blink state:
  - A frame start is detected when stage 1 samples `h==0 && v==0`.
  - `frame_cnt` counts 0..BLINK_FRAMES-1. It wraps to 0 and toggles `blink_on` on the frame start where it is BLINK_FRAMES-1.
  - `blink_on` applies from the next pipelined pixel onward.
- The cursor inputs are sampled at E1 with the coordinate. Changing them mid-frame affects only later pixels.

## Timing
- Latency: the output for the coordinate presented before E1 is valid after E3. This is exactly 3 cycles with no stalls, and the throughput is 1 pixel/cycle.
- `cell_addr_o` is valid after E1. `cell_data_i` must be stable after E2.
- Reset (async, any time, including mid-frame): all pipeline registers, `cell_addr_o`, and rgb/`use_gen` go to 0. `frame_cnt` goes to 0 and `blink_on` to 1.
- The first valid output is 3 cycles after the reset release.
- Off-board pixels never depend on `cell_data_i`, which may be X there.

## Configuration
- `BOARD_RENDERER_BLINK_EN` defined: blink counter present; the cursor alternates on/off every BLINK_FRAMES frames.
- Not defined: no `frame_cnt`/`blink_on` logic; `blink_on` is constant 1, so the cursor box is always drawn.

## Test plan
- Reset: hold `reset_n=0` during active stimulus → `cell_addr_o=0`, rgb=000000, `use_gen=0`. After release, the first valid output appears 3 cycles later.
- Cell fetch: h=341, v=209 → `cell_addr_o=23` after E1. The RAM model returns 0x40 → after E3, FF2020 with `use_gen=1`. Data 0x80 gives 2040FF; 0x00 gives `use_gen=0`.
- Grid: h=272, v=209 (lx=0) with owner 1 → 404040, `use_gen=1`. Board edge h=559 is inside; h=560 and h=239 give `use_gen=0`.
- Off-board: h=100, v=50 → `use_gen=0`, rgb=0, even with `cell_data_i=X`.
- Cursor/blink (macro on): cursor=(3,2), h=337, v=209 → FFFFFF. Apply 30 frame starts → the same pixel shows the owner colour. After 30 more → FFFFFF again. With the macro off → FFFFFF throughout.
- Cursor out of range: cursor_x=10 → no pixel is ever white over a full frame.
